pcm_tdm_serializer: RTL
=======================

# pcm_tdm_serializer

Parametrised PCM frame serializer: it buffers multi-channel sample frames in a small FIFO and serializes them onto a generated bit clock, frame clock and data line. It runs off `clk_ref_external` and supports I2S, left-justified and TDM framing. It is the successor to the fixed 2-channel, 24-bit USB-to-I2S generator in the top wrapper, and feeds the core's I2S input mux. New over the old generator: channel count, slot width and FIFO depth are parameters, framing mode is selectable, and underruns are counted.

## Interface
- `SAMPLE_W`, 24: sample bits per channel (8..32).
- `SLOT_W`, 32: bclk periods per slot (≥ `SAMPLE_W`). Unused LSB positions are driven 0.
- `CHANNELS`, 2: channels per frame (even, 2..8).
- `FIFO_DEPTH`, 4: FIFO depth in frames (power of 2, ≥2).
- `BCLK_DIV`, 4: `clk_ref_external` cycles per bclk period (even, ≥2).
- `clk_ref_external` input 1: sole clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_data` input `CHANNELS*SAMPLE_W`: one frame. Slot k is `in_data[(k+1)*SAMPLE_W-1 -: SAMPLE_W]`; slot 0 is the left channel.
- `in_valid` input 1: frame offered.
- `in_ready` output 1: FIFO not full.
- `enable` input 1: serializer run.
- `mode` input 2: 00 I2S, 01 left-justified, 10 TDM, 11 treated as I2S.
- `i2s_bclk` output 1: bit clock.
- `i2s_lrclk` output 1: word select / frame sync.
- `i2s_data` output 1: serial data, MSB first.
- `fifo_level` output `$clog2(FIFO_DEPTH)+1`: frames currently held.
- `underrun_count` output 8: frame underruns, saturates at 255.

## Operation
- **Push.** A frame is written when `in_valid && in_ready`. `in_ready = (fifo_level != FIFO_DEPTH)` and is derived from registers only. There is no bypass when full.
- **Frame geometry.** F = `CHANNELS*SLOT_W` bclk periods per frame. Bclk period index b runs 0..F-1. Phase counter p runs 0..`BCLK_DIV`-1.
  - `i2s_bclk` is 0 for p < `BCLK_DIV`/2 and 1 otherwise.
  - `i2s_lrclk` and `i2s_data` update only at p=0, the bclk falling edge.
- **Frame boundary.** The cycle with b=0, p=0 while `enable`=1.
  - At the boundary, `mode` is latched.
  - If the FIFO is non-empty, its head is popped into the shift register.
  - If the FIFO is empty, this is an underrun: `underrun_count` increments (saturating) and the shift register loads the fill frame (see Configuration).
- **Stream order.** Slot 0 MSB first through slot `CHANNELS`-1, each slot padded with 0 up to `SLOT_W`.
- **I2S mode.**
  - Data is the stream delayed by one bclk, so the slot 0 MSB appears at b=1.
  - `i2s_lrclk` = 0 for b < F/2 and 1 for b ≥ F/2.
- **Left-justified mode.**
  - No data delay; the slot 0 MSB appears at b=0.
  - `i2s_lrclk` = 1 for b < F/2 and 0 for b ≥ F/2.
- **TDM mode.**
  - Data is delayed by one bclk, as in I2S.
  - `i2s_lrclk` = 1 only at b=0.
- **Simultaneous events.** A push and a pop in the same cycle leave `fifo_level` unchanged. A push into an empty FIFO in the same cycle as a boundary does not satisfy that boundary: it counts as an underrun.
- **Enable.**
  - `enable`=0: b and p are held at 0, all three serial outputs are 0, the delay flop is cleared, and FIFO contents and pushes are unaffected.
  - Deasserting `enable` mid-frame abandons the rest of that frame.
  - The first cycle with `enable`=1 is a frame boundary.

## Timing
- **Reset values.**
  - `i2s_bclk`, `i2s_lrclk`, `i2s_data` = 0.
  - `fifo_level` = 0, `underrun_count` = 0.
  - `in_ready` = 1.
  - Internal state: b=0, p=0, shift register and hold frame = 0.
- **Mid-frame reset.** Asserting reset mid-frame clears everything immediately, including FIFO contents and `underrun_count`.
- **Registered outputs.** All serial outputs come straight from registers, updated on a `clk_ref_external` rising edge.
- **Latency.** A frame pushed into an empty FIFO at least one cycle before a boundary is popped at that boundary. Its MSB reaches `i2s_data` at:
  - 1 cycle after the boundary in left-justified mode;
  - `BCLK_DIV` cycles later in I2S and TDM modes.
- **Frame rate.** `clk_ref_external` / (`BCLK_DIV`*F). For example, `BCLK_DIV`=4, F=64 gives 1 frame per 256 cycles.

## Configuration
- `KOSEI_UNDERRUN_REPEAT_EN`
  - Defined: on underrun the last successfully popped frame is replayed (0 if none has been popped since reset).
  - Undefined: on underrun an all-zero frame is sent, and the hold register is not synthesized.

## Test plan
- **I2S basic.** Defaults, `mode`=00. Push L=0xABCDEF, R=0x123456, then `enable`=1. Sampling `i2s_data` on bclk rising edges gives b=1..24 = 0xABCDEF and b=33..56 = 0x123456, with all other bits 0. `i2s_lrclk` falls at b=0 and rises at b=32.
- **Left-justified.** Same frame with `mode`=01. The MSB appears at b=0, and `i2s_lrclk` = 1 for b=0..31.
- **TDM.** `CHANNELS`=8, `mode`=10. Push slots k = 0x100000+k. `i2s_lrclk` pulses for 1 bclk per 256 bclks, and slot k's MSB is at b=32k+1.
- **Backpressure.** `enable`=0, `FIFO_DEPTH`=4, push 5 frames. `in_ready` drops after the 4th push, `fifo_level`=4, and the 5th frame is not accepted.
- **Underrun.** Enable with an empty FIFO for 300 frames. `underrun_count`=255, and `i2s_data` is all 0 (or, with the macro defined, the last frame replayed).
- **Mid-frame reset.** Assert `rst_n`=0 at b=20. All outputs read their reset values in the same cycle, and after release the FIFO is empty with `in_ready`=1.

Source files
------------

// File: rtl/pcm_tdm_serializer.sv
// PCM frame serializer: frame FIFO feeding an I2S / left-justified / TDM shifter on a divided bit clock.
// Optional KOSEI_UNDERRUN_REPEAT_EN: replay the last popped frame on underrun instead of silence.
module pcm_tdm_serializer #(
   parameter int SAMPLE_W   = 24,
   parameter int SLOT_W     = 32,
   parameter int CHANNELS   = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int BCLK_DIV   = 4
) (
   input  logic                               clk_ref_external,
   input  logic                               rst_n,
   input  logic [CHANNELS*SAMPLE_W-1:0]       in_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               enable,
   input  logic [1:0]                         mode,
   output logic                               i2s_bclk,
   output logic                               i2s_lrclk,
   output logic                               i2s_data,
   output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
   output logic [7:0]                         underrun_count
);

   localparam int F     = CHANNELS * SLOT_W;
   localparam int FRM_W = CHANNELS * SAMPLE_W;
   localparam int P_W   = $clog2(BCLK_DIV);
   localparam int B_W   = $clog2(F);
   localparam int A_W   = $clog2(FIFO_DEPTH);
   localparam int L_W   = A_W + 1;

   logic [FRM_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [A_W-1:0]   wr_ptr, rd_ptr;
   logic [P_W-1:0]   ph_cnt;
   logic [B_W-1:0]   bit_idx;
   logic [F-1:0]     shreg;
   logic [1:0]       mode_q;
   logic             dly_bit;

   logic             push, pop, boundary, underrun, ph_tc, bit_last;
   logic [FRM_W-1:0] fill_frame, load_frame;
   logic [F-1:0]     load_stream;
   logic [1:0]       mode_eff;
   logic             is_lj, is_tdm, cur_bit;

   function automatic logic [F-1:0] to_stream(input logic [FRM_W-1:0] frm);
      logic [F-1:0] s;
      s = '0;
      for (int k = 0; k < CHANNELS; k++)
         s[F-1-k*SLOT_W -: SAMPLE_W] = frm[(k+1)*SAMPLE_W-1 -: SAMPLE_W];
      return s;
   endfunction

   // ph_cnt is the bclk phase timer counting down; terminal count 0 ends a bclk period
   assign ph_tc    = (ph_cnt == '0);
   assign bit_last = (bit_idx == B_W'(F-1));
   assign boundary = enable && (bit_idx == '0) && (ph_cnt == P_W'(BCLK_DIV-1));
   assign in_ready = (fifo_level != L_W'(FIFO_DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = boundary && (fifo_level != '0);
   assign underrun = boundary && (fifo_level == '0);

`ifdef KOSEI_UNDERRUN_REPEAT_EN
   logic [FRM_W-1:0] hold_q;
   always_ff @(posedge clk_ref_external or negedge rst_n) begin
      if (!rst_n)   hold_q <= '0;
      else if (pop) hold_q <= fifo_mem[rd_ptr];
   end
   assign fill_frame = hold_q;
`else
   assign fill_frame = '0;
`endif

   assign load_frame  = pop ? fifo_mem[rd_ptr] : fill_frame;
   assign load_stream = to_stream(load_frame);
   assign mode_eff    = boundary ? mode : mode_q;
   assign is_lj       = (mode_eff == 2'b01);
   assign is_tdm      = (mode_eff == 2'b10);
   assign cur_bit     = boundary ? load_stream[F-1] : shreg[F-1];

   always_ff @(posedge clk_ref_external) begin
      if (push) fifo_mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk_ref_external or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_level     <= '0;
         underrun_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (underrun && (underrun_count != 8'hFF))
            underrun_count <= underrun_count + 8'd1;
      end
   end

   always_ff @(posedge clk_ref_external or negedge rst_n) begin
      if (!rst_n) begin
         ph_cnt    <= P_W'(BCLK_DIV-1);
         bit_idx   <= '0;
         shreg     <= '0;
         mode_q    <= '0;
         dly_bit   <= 1'b0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= 1'b0;
         i2s_data  <= 1'b0;
      end else if (!enable) begin
         ph_cnt    <= P_W'(BCLK_DIV-1);
         bit_idx   <= '0;
         dly_bit   <= 1'b0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= 1'b0;
         i2s_data  <= 1'b0;
      end else begin
         ph_cnt   <= ph_tc ? P_W'(BCLK_DIV-1) : ph_cnt - 1'b1;
         if (ph_tc) bit_idx <= bit_last ? '0 : bit_idx + 1'b1;
         i2s_bclk <= (ph_cnt < P_W'(BCLK_DIV/2));
         // start of a bclk period: falling edge, serial outputs advance
         if (ph_cnt == P_W'(BCLK_DIV-1)) begin
            if (boundary) begin
               shreg  <= {load_stream[F-2:0], 1'b0};
               mode_q <= mode;
            end else begin
               shreg  <= {shreg[F-2:0], 1'b0};
            end
            dly_bit  <= cur_bit;
            i2s_data <= is_lj ? cur_bit : dly_bit;
            if (is_tdm)
               i2s_lrclk <= (bit_idx == '0);
            else if (is_lj)
               i2s_lrclk <= (bit_idx < B_W'(F/2));
            else
               i2s_lrclk <= (bit_idx >= B_W'(F/2));
         end
      end
   end

endmodule
